// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte stream to Unicode code point decoder with maximal-subpart error
// replacement (U+FFFD), optional leading BOM removal and a saturating error count.
module utf8_stream_decoder #(
    parameter bit STRIP_BOM = 1'b1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [20:0]          out_cp,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        CONT,
        REPLAY
    } state_t;

    localparam logic [20:0] REPLACEMENT = 21'h0FFFD;
    localparam logic [20:0] BOM_CP      = 21'h0FEFF;
    localparam logic [7:0]  CONT_LO     = 8'h80;
    localparam logic [7:0]  CONT_HI     = 8'hBF;

    state_t               state, state_n;
    logic [1:0]           need, need_n;
    logic [14:0]          acc, acc_n;
    logic [7:0]           lo, lo_n;
    logic [7:0]           hi, hi_n;
    logic [7:0]           replay_byte, replay_n;
    logic                 bom_window, bom_window_n;
    logic                 out_valid_n;
    logic [20:0]          out_cp_n;
    logic                 out_err_n;
    logic [ERR_CNT_W-1:0] err_count_n;

    logic                 slot_free;
    logic                 lead_go;
    logic [7:0]           lead_byte;
    logic                 emit;
    logic                 emit_err;
    logic [20:0]          emit_cp;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state != REPLAY) && slot_free;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_n      = state;
        need_n       = need;
        acc_n        = acc;
        lo_n         = lo;
        hi_n         = hi;
        replay_n     = replay_byte;
        bom_window_n = bom_window;
        out_valid_n  = out_valid && !out_ready;
        out_cp_n     = out_cp;
        out_err_n    = out_err;
        err_count_n  = err_count;
        lead_go      = 1'b0;
        lead_byte    = in_data;
        emit         = 1'b0;
        emit_err     = 1'b0;
        emit_cp      = '0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    lead_go = 1'b1;
                end
            end
            CONT: begin
                if (in_valid && in_ready) begin
                    if (in_data >= lo && in_data <= hi) begin
                        acc_n  = {acc[8:0], in_data[5:0]};
                        need_n = need - 2'd1;
                        lo_n   = CONT_LO;
                        hi_n   = CONT_HI;
                        if (need == 2'd1) begin
                            emit    = 1'b1;
                            emit_cp = {acc, in_data[5:0]};
                            state_n = IDLE;
                        end
                    end else begin
                        // The offending byte is consumed now and re-examined as a lead byte.
                        emit     = 1'b1;
                        emit_err = 1'b1;
                        emit_cp  = REPLACEMENT;
                        replay_n = in_data;
                        state_n  = REPLAY;
                    end
                end
            end
            REPLAY: begin
                if (slot_free) begin
                    lead_go   = 1'b1;
                    lead_byte = replay_byte;
                end
            end
            default: state_n = IDLE;
        endcase

        if (lead_go) begin
            state_n = IDLE;
            lo_n    = CONT_LO;
            hi_n    = CONT_HI;
            if (lead_byte <= 8'h7F) begin
                emit    = 1'b1;
                emit_cp = {13'd0, lead_byte};
            end else if (lead_byte >= 8'hC2 && lead_byte <= 8'hDF) begin
                need_n  = 2'd1;
                acc_n   = {10'd0, lead_byte[4:0]};
                state_n = CONT;
            end else if (lead_byte >= 8'hE0 && lead_byte <= 8'hEF) begin
                need_n  = 2'd2;
                acc_n   = {11'd0, lead_byte[3:0]};
                state_n = CONT;
                // Narrowed first-continuation windows reject overlongs and surrogates.
                if (lead_byte == 8'hE0) lo_n = 8'hA0;
                if (lead_byte == 8'hED) hi_n = 8'h9F;
            end else if (lead_byte >= 8'hF0 && lead_byte <= 8'hF4) begin
                need_n  = 2'd3;
                acc_n   = {12'd0, lead_byte[2:0]};
                state_n = CONT;
                if (lead_byte == 8'hF0) lo_n = 8'h90;
                if (lead_byte == 8'hF4) hi_n = 8'h8F;
            end else begin
                emit     = 1'b1;
                emit_err = 1'b1;
                emit_cp  = REPLACEMENT;
            end
        end

        if (emit) begin
            if (emit_err) begin
                out_valid_n = 1'b1;
                out_cp_n    = emit_cp;
                out_err_n   = 1'b1;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count_n = err_count + ERR_CNT_W'(1);
                end
            end else begin
                bom_window_n = 1'b0;
                if (!(STRIP_BOM && bom_window && emit_cp == BOM_CP)) begin
                    out_valid_n = 1'b1;
                    out_cp_n    = emit_cp;
                    out_err_n   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            need        <= 2'd0;
            acc         <= '0;
            lo          <= CONT_LO;
            hi          <= CONT_HI;
            replay_byte <= 8'h00;
            bom_window  <= 1'b1;
            out_valid   <= 1'b0;
            out_cp      <= '0;
            out_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            state       <= state_n;
            need        <= need_n;
            acc         <= acc_n;
            lo          <= lo_n;
            hi          <= hi_n;
            replay_byte <= replay_n;
            bom_window  <= bom_window_n;
            out_valid   <= out_valid_n;
            out_cp      <= out_cp_n;
            out_err     <= out_err_n;
            err_count   <= err_count_n;
        end
    end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Bench for utf8_stream_decoder: directed scenarios plus randomized streams
// compared against an index-based lookahead UTF-8 decoding model.
module tb_utf8_stream_decoder;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [20:0] out_cp;
    logic        out_err;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim[$];
    logic [21:0] exp_q[$];
    logic [21:0] got[$];
    int          exp_errs;
    int          stab_viol;
    int          low_ready_cycles;
    bit          ready_mode = 1'b0;
    bit          ready_force = 1'b1;

    utf8_stream_decoder #(.STRIP_BOM(1'b1), .ERR_CNT_W(16)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cp    (out_cp),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Output monitor: records transferred beats and checks hold stability.
    initial begin
        bit          prev_hold;
        logic [21:0] prev_beat;
        prev_hold = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && (!out_valid || {out_err, out_cp} != prev_beat)) stab_viol++;
                if (!in_ready) low_ready_cycles++;
                if (out_valid && out_ready) got.push_back({out_err, out_cp});
                prev_hold = out_valid && !out_ready;
                prev_beat = {out_err, out_cp};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] beat(input bit e, input int cp);
        return {e, 21'(cp)};
    endfunction

    task automatic push_cp(input int cp);
        if (cp < 'h80) begin
            stim.push_back(8'(cp));
        end else if (cp < 'h800) begin
            stim.push_back(8'('hC0 | (cp >> 6)));
            stim.push_back(8'('h80 | (cp & 'h3F)));
        end else if (cp < 'h10000) begin
            stim.push_back(8'('hE0 | (cp >> 12)));
            stim.push_back(8'('h80 | ((cp >> 6) & 'h3F)));
            stim.push_back(8'('h80 | (cp & 'h3F)));
        end else begin
            stim.push_back(8'('hF0 | (cp >> 18)));
            stim.push_back(8'('h80 | ((cp >> 12) & 'h3F)));
            stim.push_back(8'('h80 | ((cp >> 6) & 'h3F)));
            stim.push_back(8'('h80 | (cp & 'h3F)));
        end
    endtask

    // Reference: scan bytes by index, look ahead over the expected sequence length.
    task automatic build_expected();
        int         i, n, len, cp;
        logic [7:0] b, c, lo, hi, l, h;
        bit         bom_open, ok, trunc;
        exp_q.delete();
        exp_errs = 0;
        bom_open = 1'b1;
        trunc    = 1'b0;
        i        = 0;
        n        = stim.size();
        while (i < n && !trunc) begin
            b  = stim[i];
            i++;
            lo = 8'h80;
            hi = 8'hBF;
            if (b < 8'h80) begin
                len = 0; cp = int'(b);
            end else if (b >= 8'hC2 && b <= 8'hDF) begin
                len = 1; cp = int'(b & 8'h1F);
            end else if (b >= 8'hE0 && b <= 8'hEF) begin
                len = 2; cp = int'(b & 8'h0F);
                if (b == 8'hE0) lo = 8'hA0;
                if (b == 8'hED) hi = 8'h9F;
            end else if (b >= 8'hF0 && b <= 8'hF4) begin
                len = 3; cp = int'(b & 8'h07);
                if (b == 8'hF0) lo = 8'h90;
                if (b == 8'hF4) hi = 8'h8F;
            end else begin
                exp_q.push_back(beat(1'b1, 'hFFFD));
                exp_errs++;
                continue;
            end
            ok = 1'b1;
            for (int k = 0; k < len; k++) begin
                if (i >= n) begin
                    trunc = 1'b1; ok = 1'b0; break;
                end
                c = stim[i];
                l = (k == 0) ? lo : 8'h80;
                h = (k == 0) ? hi : 8'hBF;
                if (c < l || c > h) begin
                    exp_q.push_back(beat(1'b1, 'hFFFD));
                    exp_errs++;
                    ok = 1'b0;
                    break;
                end
                cp = cp * 64 + int'(c & 8'h3F);
                i++;
            end
            if (ok) begin
                if (bom_open) begin
                    bom_open = 1'b0;
                    if (cp == 'hFEFF) continue;
                end
                exp_q.push_back(beat(1'b0, cp));
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        got.delete();
        stab_viol        = 0;
        low_ready_cycles = 0;
    endtask

    task automatic drive_stim(input bit gaps);
        int budget;
        foreach (stim[j]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_data  = stim[j];
            budget   = 0;
            forever begin
                @(negedge clock);
                if (in_ready) break;
                budget++;
                if (budget > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL drive_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (got.size() < exp_q.size() && k < 2000) begin
            @(posedge clock);
            k++;
        end
        repeat (10) @(posedge clock);
        #1;
    endtask

    task automatic compare_results(input string name);
        int m;
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, got.size(), exp_q.size());
        end
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got err=%0b cp=%h, required err=%0b cp=%h",
                         name, i, got[i][21], got[i][20:0], exp_q[i][21], exp_q[i][20:0]);
            end
        end
        checks++;
        if (err_count !== 16'(exp_errs)) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, exp_errs);
        end
        checks++;
        if (stab_viol !== 0) begin
            errors++;
            $display("FAIL %s_stability: got %0d unstable holds, required 0", name, stab_viol);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_cp !== 21'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got valid=%0b cp=%h err=%0b, required 0 0 0", out_valid, out_cp, out_err);
        end
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_err_count: got %0d, required 0", err_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        do_reset();
    endtask

    task automatic test_basic_latency();
        logic [7:0]  bytes[8] = '{8'h41, 8'hE1, 8'h9A, 8'hBB, 8'hF0, 8'h9F, 8'h98, 8'h80};
        bit          last[8]  = '{1, 0, 0, 1, 0, 0, 0, 1};
        logic [20:0] cps[8]   = '{21'h41, 0, 0, 21'h16BB, 0, 0, 0, 21'h1F600};
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        @(posedge clock);
        #1;
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                in_valid = 1'b1;
                in_data  = bytes[j];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (j > 0) begin
                checks++;
                if (out_valid !== last[j-1] || (last[j-1] && (out_cp !== cps[j-1] || out_err !== 1'b0))) begin
                    errors++;
                    $display("FAIL latency_byte%0d: got valid=%0b cp=%h err=%0b, required valid=%0b cp=%h err=0",
                             j - 1, out_valid, out_cp, out_err, last[j-1], cps[j-1]);
                end
            end
            if (j < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_in_ready%0d: got %0b, required 1", j, in_ready);
                end
            end
            @(posedge clock);
            #1;
        end
        exp_q.delete();
        exp_q.push_back(beat(1'b0, 'h41));
        exp_q.push_back(beat(1'b0, 'h16BB));
        exp_q.push_back(beat(1'b0, 'h1F600));
        exp_errs = 0;
        drain();
        compare_results("basic");
    endtask

    task automatic test_bom();
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        stim = '{8'hEF, 8'hBB, 8'hBF, 8'h41, 8'hEF, 8'hBB, 8'hBF};
        exp_q.delete();
        exp_q.push_back(beat(1'b0, 'h41));
        exp_q.push_back(beat(1'b0, 'hFEFF));
        exp_errs = 0;
        drive_stim(1'b0);
        drain();
        compare_results("bom");
    endtask

    task automatic test_replay();
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        stim = '{8'hE1, 8'h9A, 8'h41};
        exp_q.delete();
        exp_q.push_back(beat(1'b1, 'hFFFD));
        exp_q.push_back(beat(1'b0, 'h41));
        exp_errs = 1;
        drive_stim(1'b0);
        drain();
        compare_results("replay");
        checks++;
        if (low_ready_cycles !== 1) begin
            errors++;
            $display("FAIL replay_stall: got %0d in_ready-low cycles, required 1", low_ready_cycles);
        end
    endtask

    task automatic test_surrogate();
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        stim = '{8'hC0, 8'h80, 8'hED, 8'hA0, 8'h80};
        exp_q.delete();
        repeat (5) exp_q.push_back(beat(1'b1, 'hFFFD));
        exp_errs = 5;
        drive_stim(1'b0);
        drain();
        compare_results("surrogate");
        checks++;
        if (low_ready_cycles !== 1) begin
            errors++;
            $display("FAIL surrogate_stall: got %0d in_ready-low cycles, required 1", low_ready_cycles);
        end
    endtask

    task automatic test_back_pressure();
        int budget;
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        ready_force = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got %0b, required 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_data = 8'h42;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_cp !== 21'h41 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%0b cp=%h err=%0b, required 1 00041 0", c, out_valid, out_cp, out_err);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready%0d: got %0b, required 0", c, in_ready);
            end
            @(posedge clock);
            #1;
        end
        ready_force = 1'b1;
        budget = 0;
        forever begin
            @(negedge clock);
            if (in_ready || budget > 100) break;
            budget++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(beat(1'b0, 'h41));
        exp_q.push_back(beat(1'b0, 'h42));
        exp_errs = 0;
        drain();
        compare_results("back_pressure");
    endtask

    task automatic test_reset_mid();
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        do_reset();
        stim = '{8'hE1, 8'h9A};
        drive_stim(1'b0);
        rst_n = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b err_count=%0d, required 0 0", out_valid, err_count);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        got.delete();
        stab_viol = 0;
        stim = '{8'h43};
        exp_q.delete();
        exp_q.push_back(beat(1'b0, 'h43));
        exp_errs = 0;
        drive_stim(1'b0);
        drain();
        compare_results("reset_mid");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            ready_mode = 1'b1;
            do_reset();
            stim.delete();
            if (r % 2 == 1) push_cp('hFEFF);
            repeat (30) begin
                case ($urandom_range(0, 7))
                    0: push_cp(int'($urandom_range(0, 'h7F)));
                    1: push_cp(int'($urandom_range('h80, 'h7FF)));
                    2: push_cp(int'($urandom_range('h800, 'hFFFF)));
                    3: push_cp(int'($urandom_range('h10000, 'h10FFFF)));
                    4: stim.push_back(8'($urandom_range(0, 255)));
                    5: begin
                        push_cp(int'($urandom_range('h800, 'h10FFFF)));
                        void'(stim.pop_back());
                    end
                    6: push_cp(int'($urandom_range('hD800, 'hDFFF)));
                    default: begin
                        int v;
                        v = int'($urandom_range(0, 'h7FF));
                        stim.push_back(8'hE0);
                        stim.push_back(8'('h80 | (v >> 6)));
                        stim.push_back(8'('h80 | (v & 'h3F)));
                    end
                endcase
            end
            build_expected();
            drive_stim(1'b1);
            drain();
            compare_results($sformatf("random%0d", r));
        end
        ready_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_bom();
        test_replay();
        test_surrogate();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
Converts a byte stream of UTF-8 text into a stream of Unicode code points, one code point per output beat. It sits downstream of the byte source and upstream of the code-point consumers. It applies the Unicode "maximal subpart" error policy, emitting U+FFFD with an error flag for malformed input. It can optionally drop a leading byte order mark (U+FEFF).

Parameters:
STRIP_BOM, 1, when 1 the first code point decoded after reset is discarded if it equals 0xFEFF
ERR_CNT_W, 16, width of the saturating malformed-sequence counter

Ports:
clock  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a byte
in_ready  output  1  decoder accepts the byte this cycle
in_data  input  8  UTF-8 byte
out_valid  output  1  out_cp/out_err hold a decoded beat
out_ready  input  1  consumer accepts the beat this cycle
out_cp  output  21  code point (U+0000..U+10FFFF)
out_err  output  1  beat is a U+FFFD replacement for malformed input
err_count  output  ERR_CNT_W  number of error beats since reset, saturates at all-ones

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_cp=0, out_err=0, err_count=0, state IDLE, need=0, acc=0, bom_window=1.
- Handshake: byte transfers when in_valid&&in_ready; beat transfers when out_valid&&out_ready. out_valid, once high, stays high with stable out_cp/out_err until transferred. in_ready = (state!=REPLAY) && (!out_valid || out_ready); it never depends on in_data.
- Single output register. Latency: beat appears with out_valid high in the cycle after its final byte is accepted. Sustained throughput is 1 byte/cycle when out_ready=1.
- States: IDLE (expect lead byte), CONT (need 1..3 continuation bytes), REPLAY (hold one rejected byte for reprocessing as a lead byte).
- IDLE lead decode:
  - 00-7F: emit cp=byte.
  - C2-DF: need=1, acc=byte[4:0].
  - E0-EF: need=2, acc=byte[3:0].
  - F0-F4: need=3, acc=byte[2:0].
  - 80-BF, C0, C1, F5-FF: emit FFFD with err=1 and stay in IDLE.
- CONT: a byte is valid if it is 80-BF, with a narrower window for the first continuation byte: after E0 it must be A0-BF; after ED, 80-9F; after F0, 90-BF; after F4, 80-8F.
  - Valid byte: acc={acc,byte[5:0]}, need-1. When need reaches 0, emit acc and go to IDLE.
  - Invalid byte: accept it, emit FFFD with err=1, latch the byte, go to REPLAY.
- REPLAY: once the output slot is free (!out_valid || out_ready), process the latched byte exactly as an IDLE lead byte, without consuming input that cycle.
- BOM: bom_window clears when the first non-error code point is produced. If STRIP_BOM=1 and that code point is 0xFEFF, it is dropped: out_valid is not asserted and nothing is counted. Error beats do not close the window.
- err_count increments by 1 per error beat at the moment it is emitted, and saturates at all-ones.
- Reset mid-sequence discards any partial accumulation and any pending beat. There is no end-of-stream flush: a truncated sequence at stream end stays pending in CONT.

Test Plan:
- 41, then E1 9A BB, then F0 9F 98 80 with out_ready=1 -> beats 0x00041, 0x016BB, 0x1F600, all err=0. Each beat appears one cycle after its last byte.
- STRIP_BOM=1: EF BB BF 41 -> single beat 0x41. Repeat EF BB BF after it -> beat 0xFEFF is emitted, because only the first code point is stripped.
- E1 9A 41 -> beat FFFD err=1, then beat 0x41. in_ready is low for exactly the REPLAY cycle. err_count=1.
- C0 80 ED A0 80 -> FFFD, FFFD, FFFD, FFFD, FFFD, each err=1, err_count=5 (ED A0 is a surrogate, so A0 is rejected and replayed as a stray byte).
- Hold out_ready=0 while streaming 41 42 -> first beat 0x41 holds stable and in_ready drops. Raise out_ready -> 0x41 then 0x42 delivered with no loss or duplication.
- Assert rst_n=0 after E1 9A, then release and send 43 -> single beat 0x43, with out_valid=0 and err_count=0 during reset.
